// File: rtl/fighter_action_ctrl_if.sv
// Pad-side and game-side signals of one player's action sequencer.
// The controller takes the slave view. Game logic or the bench takes the master view.
interface fighter_action_ctrl_if;
    logic       left_l;
    logic       right_l;
    logic       up_l;
    logic       down_l;
    logic       attack;
    logic       shield;
    logic       frame_tick;
    logic [2:0] state;
    logic       move_left;
    logic       move_right;
    logic       jump;
    logic       crouch;
    logic       hitbox_active;
    logic       shielding;
    logic       busy;

    modport slave (
        input  left_l, right_l, up_l, down_l, attack, shield,
        output frame_tick, state, move_left, move_right, jump, crouch,
               hitbox_active, shielding, busy
    );

    modport master (
        output left_l, right_l, up_l, down_l, attack, shield,
        input  frame_tick, state, move_left, move_right, jump, crouch,
               hitbox_active, shielding, busy
    );
endinterface

// File: rtl/fighter_action_ctrl.sv
// Per-player action sequencer. It synchronises the pad, derives the frame tick and
// sequences attack phases, shield hold/cooldown and movement on frame boundaries.
module fighter_action_ctrl #(
    parameter int TICK_DIV    = 1666667,
    parameter int ATK_STARTUP = 3,
    parameter int ATK_ACTIVE  = 4,
    parameter int ATK_RECOVER = 6,
    parameter int SHIELD_MAX  = 90,
    parameter int SHIELD_CD   = 60
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fighter_action_ctrl_if.slave  pad
);
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_MOVE        = 3'd1,
        S_ATK_START   = 3'd2,
        S_ATK_ACTIVE  = 3'd3,
        S_ATK_RECOVER = 3'd4,
        S_SHIELD      = 3'd5,
        S_SHIELD_COOL = 3'd6,
        S_UNUSED      = 3'd7
    } state_t;

    localparam int DW    = $clog2(TICK_DIV);
    localparam int PM_A  = (ATK_STARTUP > ATK_ACTIVE) ? ATK_STARTUP : ATK_ACTIVE;
    localparam int PM_B  = (ATK_RECOVER > PM_A) ? ATK_RECOVER : PM_A;
    localparam int PM_C  = (SHIELD_MAX > PM_B) ? SHIELD_MAX : PM_B;
    localparam int PMAX  = (SHIELD_CD > PM_C) ? SHIELD_CD : PM_C;
    localparam int PW    = $clog2(PMAX + 1);

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt;
    logic [PW-1:0]   pcnt;
    logic [5:0]      sync1, sync2, raw;
    logic            atk_prev, atk_req, atk_edge;
    logic            tick, shield_s, any_dir, idle_like, req_clr;
    logic [3:0]      dir_res, dir_q;

    // Bit order: left, right, up, down, attack, shield. Directions become active-high here.
    assign raw = {~pad.left_l, ~pad.right_l, ~pad.up_l, ~pad.down_l, pad.attack, pad.shield};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            atk_prev <= 1'b0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            atk_prev <= sync2[1];
        end
    end

    assign atk_edge = sync2[1] & ~atk_prev;
    assign shield_s = sync2[0];
    assign dir_res  = {sync2[5] & ~sync2[4], sync2[4] & ~sync2[5],
                       sync2[3] & ~sync2[2], sync2[2] & ~sync2[3]};
    assign any_dir  = |dir_res;

    assign tick = (div_cnt == DW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n)  div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_UNUSED) begin
            state_d = S_IDLE;
        end else if (tick) begin
            case (state_q)
                S_IDLE, S_MOVE: begin
                    if (atk_req)       state_d = S_ATK_START;
                    else if (shield_s) state_d = S_SHIELD;
                    else if (any_dir)  state_d = S_MOVE;
                    else               state_d = S_IDLE;
                end
                S_ATK_START:   if (pcnt == PW'(ATK_STARTUP - 1)) state_d = S_ATK_ACTIVE;
                S_ATK_ACTIVE:  if (pcnt == PW'(ATK_ACTIVE - 1))  state_d = S_ATK_RECOVER;
                S_ATK_RECOVER: if (pcnt == PW'(ATK_RECOVER - 1)) state_d = S_IDLE;
                S_SHIELD:      if (!shield_s || pcnt == PW'(SHIELD_MAX - 1)) state_d = S_SHIELD_COOL;
                S_SHIELD_COOL: if (pcnt == PW'(SHIELD_CD - 1))   state_d = S_IDLE;
                default:       state_d = S_IDLE;
            endcase
        end
    end

    assign idle_like = (state_q == S_IDLE) || (state_q == S_MOVE);
    // Busy states never carry a press past a frame boundary.
    assign req_clr   = tick && (idle_like ? (state_d == S_ATK_START) : 1'b1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcnt    <= '0;
            dir_q   <= '0;
            atk_req <= 1'b0;
        end else begin
            if (state_d != state_q) pcnt <= '0;
            else if (tick)          pcnt <= pcnt + 1'b1;
            if (tick)               dir_q <= (state_d == S_MOVE) ? dir_res : 4'b0;
            if (req_clr)            atk_req <= 1'b0;
            else if (atk_edge)      atk_req <= 1'b1;
        end
    end

    assign pad.frame_tick    = tick;
    assign pad.state         = state_q;
    assign pad.move_left     = (state_q == S_MOVE) & dir_q[3];
    assign pad.move_right    = (state_q == S_MOVE) & dir_q[2];
    assign pad.jump          = (state_q == S_MOVE) & dir_q[1];
    assign pad.crouch        = (state_q == S_MOVE) & dir_q[0];
    assign pad.hitbox_active = (state_q == S_ATK_ACTIVE);
    assign pad.shielding     = (state_q == S_SHIELD);
    assign pad.busy          = (state_q >= S_ATK_START) && (state_q <= S_SHIELD_COOL);
endmodule

// File: tb/tb_fighter_action_ctrl.sv
// Directed bench for fighter_action_ctrl. It uses a short frame and short phase lengths,
// and it drives inputs and samples outputs on the falling clock edge.
module tb_fighter_action_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    fighter_action_ctrl_if ifc ();

    fighter_action_ctrl #(
        .TICK_DIV(4), .ATK_STARTUP(2), .ATK_ACTIVE(3), .ATK_RECOVER(2),
        .SHIELD_MAX(5), .SHIELD_CD(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pad(ifc)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        int n = 0;
        step(1);
        while (!ifc.frame_tick && n < 20) begin n++; step(1); end
        if (!ifc.frame_tick) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_tick: no frame_tick within 20 cycles");
        end
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (ifc.state != s && n < 200) begin n++; step(1); end
        if (ifc.state != s) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_state: state=%0d never reached %0d", ifc.state, s);
        end
    endtask

    task automatic run_len(input logic [2:0] s, output int n);
        n = 0;
        while (ifc.state == s && n < 200) begin n++; step(1); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(3);
        tests_run++;
        if ({ifc.state, ifc.frame_tick, ifc.move_left, ifc.move_right, ifc.jump, ifc.crouch,
             ifc.hitbox_active, ifc.shielding, ifc.busy} !== 11'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: state=%0d tick=%b busy=%b expected all 0",
                     ifc.state, ifc.frame_tick, ifc.busy);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            tests_run++;
            if (ifc.frame_tick !== ((k % 4) == 3)) begin
                tests_failed++;
                $display("FAIL tick_cycle_%0d: frame_tick=%b expected %b", k, ifc.frame_tick, (k % 4) == 3);
            end
        end
        tests_run++;
        if (ifc.state !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_idle: state=%0d expected 0", ifc.state);
        end
    endtask

    task automatic test_attack();
        int c2 = 0, c3 = 0, c4 = 0, hb = 0, bz = 0, guard = 0;
        wait_tick();
        ifc.attack = 1'b1; step(2);
        ifc.attack = 1'b0; step(2);
        tests_run++;
        if (ifc.state !== 3'd0) begin
            tests_failed++; $display("FAIL atk_pre: state=%0d expected 0", ifc.state);
        end
        step(1);
        tests_run++;
        if (ifc.state !== 3'd2 || ifc.busy !== 1'b1) begin
            tests_failed++; $display("FAIL atk_enter: state=%0d busy=%b expected 2/1", ifc.state, ifc.busy);
        end
        while (ifc.state != 3'd0 && guard < 100) begin
            if (ifc.state == 3'd2) c2++;
            if (ifc.state == 3'd3) c3++;
            if (ifc.state == 3'd4) c4++;
            if (ifc.hitbox_active) hb++;
            if (ifc.busy) bz++;
            guard++; step(1);
        end
        tests_run++;
        if (c2 != 8 || c3 != 12 || c4 != 8) begin
            tests_failed++; $display("FAIL atk_phases: start=%0d active=%0d recover=%0d expected 8/12/8", c2, c3, c4);
        end
        tests_run++;
        if (hb != 12) begin
            tests_failed++; $display("FAIL atk_hitbox: %0d cycles expected 12", hb);
        end
        tests_run++;
        if (bz != 28) begin
            tests_failed++; $display("FAIL atk_busy: %0d cycles expected 28", bz);
        end
    endtask

    task automatic test_priority();
        int n;
        wait_tick();
        ifc.attack = 1'b1; ifc.shield = 1'b1; step(2);
        ifc.attack = 1'b0; step(3);
        tests_run++;
        if (ifc.state !== 3'd2) begin
            tests_failed++; $display("FAIL prio_attack: state=%0d expected 2", ifc.state);
        end
        run_len(3'd2, n);
        ifc.attack = 1'b1; step(2);
        ifc.attack = 1'b0;
        wait_state(3'd4);
        run_len(3'd4, n);
        tests_run++;
        if (ifc.state !== 3'd0) begin
            tests_failed++; $display("FAIL prio_recover_exit: state=%0d expected 0", ifc.state);
        end
        run_len(3'd0, n);
        tests_run++;
        if (n != 4 || ifc.state !== 3'd5 || ifc.shielding !== 1'b1) begin
            tests_failed++;
            $display("FAIL prio_discard: idle=%0d state=%0d shielding=%b expected 4/5/1", n, ifc.state, ifc.shielding);
        end
    endtask

    task automatic test_shield_timeout();
        int n;
        run_len(3'd5, n);
        tests_run++;
        if (n != 20 || ifc.state !== 3'd6) begin
            tests_failed++; $display("FAIL shield_max: %0d cycles then state=%0d expected 20/6", n, ifc.state);
        end
        run_len(3'd6, n);
        tests_run++;
        if (n != 12 || ifc.state !== 3'd0 || ifc.busy !== 1'b0) begin
            tests_failed++; $display("FAIL shield_cool: %0d cycles then state=%0d expected 12/0", n, ifc.state);
        end
        run_len(3'd0, n);
        tests_run++;
        if (n != 4 || ifc.state !== 3'd5) begin
            tests_failed++; $display("FAIL shield_reenter: idle=%0d state=%0d expected 4/5", n, ifc.state);
        end
        ifc.shield = 1'b0;
        step(1);
        wait_state(3'd0);
    endtask

    task automatic test_movement();
        wait_tick();
        ifc.left_l = 1'b0; step(4);
        tests_run++;
        if (ifc.state !== 3'd0) begin
            tests_failed++; $display("FAIL move_pre: state=%0d expected 0", ifc.state);
        end
        step(1);
        tests_run++;
        if ({ifc.state, ifc.move_left, ifc.move_right, ifc.jump, ifc.crouch} !== {3'd1, 4'b1000}) begin
            tests_failed++; $display("FAIL move_left: state=%0d l/r/j/c=%b%b%b%b expected 1/1000",
                                     ifc.state, ifc.move_left, ifc.move_right, ifc.jump, ifc.crouch);
        end
        ifc.right_l = 1'b0; step(3);
        tests_run++;
        if (ifc.state !== 3'd1 || ifc.move_left !== 1'b1) begin
            tests_failed++; $display("FAIL move_hold: state=%0d move_left=%b expected 1/1", ifc.state, ifc.move_left);
        end
        step(1);
        tests_run++;
        if ({ifc.state, ifc.move_left, ifc.move_right, ifc.jump, ifc.crouch} !== 7'd0) begin
            tests_failed++; $display("FAIL move_cancel: state=%0d l/r/j/c=%b%b%b%b expected 0/0000",
                                     ifc.state, ifc.move_left, ifc.move_right, ifc.jump, ifc.crouch);
        end
        ifc.left_l = 1'b1; ifc.right_l = 1'b1; ifc.up_l = 1'b0; step(4);
        tests_run++;
        if ({ifc.state, ifc.move_left, ifc.move_right, ifc.jump, ifc.crouch} !== {3'd1, 4'b0010}) begin
            tests_failed++; $display("FAIL move_jump: state=%0d l/r/j/c=%b%b%b%b expected 1/0010",
                                     ifc.state, ifc.move_left, ifc.move_right, ifc.jump, ifc.crouch);
        end
        ifc.up_l = 1'b1; ifc.down_l = 1'b0; step(4);
        tests_run++;
        if ({ifc.state, ifc.move_left, ifc.move_right, ifc.jump, ifc.crouch} !== {3'd1, 4'b0001}) begin
            tests_failed++; $display("FAIL move_crouch: state=%0d l/r/j/c=%b%b%b%b expected 1/0001",
                                     ifc.state, ifc.move_left, ifc.move_right, ifc.jump, ifc.crouch);
        end
        ifc.down_l = 1'b1; step(4);
        tests_run++;
        if (ifc.state !== 3'd0 || ifc.crouch !== 1'b0) begin
            tests_failed++; $display("FAIL move_release: state=%0d crouch=%b expected 0/0", ifc.state, ifc.crouch);
        end
    endtask

    task automatic test_reset_mid_attack();
        int bad = 0, ticks = 0;
        wait_tick();
        ifc.attack = 1'b1; step(2);
        ifc.attack = 1'b0;
        wait_state(3'd3);
        step(1);
        reset_n = 1'b0; step(1);
        tests_run++;
        if (ifc.state !== 3'd0 || ifc.hitbox_active !== 1'b0 || ifc.busy !== 1'b0) begin
            tests_failed++; $display("FAIL midreset: state=%0d hitbox=%b busy=%b expected 0/0/0",
                                     ifc.state, ifc.hitbox_active, ifc.busy);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (ifc.state != 3'd0) bad++;
            if (ifc.frame_tick) ticks++;
        end
        tests_run++;
        if (bad != 0 || ticks != 3) begin
            tests_failed++; $display("FAIL midreset_replay: non-idle=%0d ticks=%0d expected 0/3", bad, ticks);
        end
    endtask

    initial begin
        ifc.left_l = 1'b1; ifc.right_l = 1'b1; ifc.up_l = 1'b1; ifc.down_l = 1'b1;
        ifc.attack = 1'b0; ifc.shield = 1'b0;
        test_reset();
        test_attack();
        test_priority();
        test_shield_timeout();
        test_movement();
        test_reset_mid_attack();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/fighter_action_ctrl.md
Name: fighter_action_ctrl

Overview:
Per-player action sequencer between the joystick/button pins and game logic. Synchronises raw pad inputs and generates a frame tick. Arbitrates between attack, shield and movement requests, and sequences timed attack phases (startup/active/recovery) and shield hold/cooldown. One instance per player; outputs feed sprite/hitbox logic and debug LEDs.

Parameters:
TICK_DIV, 1666667, clk cycles per frame tick (100 MHz -> 60 Hz); legal range >=2
ATK_STARTUP, 3, frames in ATK_START; legal range >=1
ATK_ACTIVE, 4, frames in ATK_ACTIVE (hitbox live); legal range >=1
ATK_RECOVER, 6, frames in ATK_RECOVER; legal range >=1
SHIELD_MAX, 90, max consecutive frames in SHIELD; legal range >=1
SHIELD_CD, 60, frames in SHIELD_COOL; legal range >=1

Ports:
clk  in  1  system clock, all logic rising-edge
reset_n  in  1  synchronous active-low reset
left_l  in  1  joystick left, active-low, asynchronous
right_l  in  1  joystick right, active-low, asynchronous
up_l  in  1  joystick up, active-low, asynchronous
down_l  in  1  joystick down, active-low, asynchronous
attack  in  1  attack button, active-high, asynchronous
shield  in  1  shield button, active-high, asynchronous
frame_tick  out  1  one-cycle pulse per frame
state  out  3  current state code
move_left / move_right / jump / crouch  out  1 each  movement commands
hitbox_active  out  1  high in ATK_ACTIVE
shielding  out  1  high in SHIELD
busy  out  1  high in any ATK_* or SHIELD* state

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, every output 0. Divider, phase counter, synchroniser flops, direction register and attack_req all cleared.
- Synchroniser: 2-flop sync on all six inputs. Directions are inverted to active-high internally. A synchronised input is usable 2 cycles after a pin change.
- Divider: 0..TICK_DIV-1 wrap counter. frame_tick=1 for exactly one cycle when count==TICK_DIV-1. The first tick occurs on cycle TICK_DIV-1 after reset release.
- attack_req: set on a synchronised attack rising edge, in any cycle. It is consumed (cleared) when IDLE/MOVE enters ATK_START. It is also cleared on any tick while the state is ATK_*, SHIELD or SHIELD_COOL (no input buffering through busy states). If an edge and a clearing tick occur in the same cycle, the clear wins.
- State codes: IDLE=0, MOVE=1, ATK_START=2, ATK_ACTIVE=3, ATK_RECOVER=4, SHIELD=5, SHIELD_COOL=6; 7 is unused and recovers to IDLE on the next cycle.
- Transitions are evaluated only on frame_tick cycles and are registered, so state changes on the clk edge ending the tick cycle.
- Phase counter pcnt: cleared on every state change; increments on each tick that does not change state.
- IDLE/MOVE at tick, in priority order:
  1. attack_req -> ATK_START.
  2. Else synchronised shield -> SHIELD.
  3. Else any resolved direction -> MOVE.
  4. Else -> IDLE.
- Direction resolution: opposite directions pressed together cancel (left&right -> neither; up&down -> neither). The direction register is loaded at each tick that lands in MOVE and cleared otherwise.
- Movement outputs reflect the direction register and are 0 outside MOVE.
- ATK_START: exit to ATK_ACTIVE at a tick with pcnt==ATK_STARTUP-1.
- ATK_ACTIVE: exit to ATK_RECOVER at a tick with pcnt==ATK_ACTIVE-1.
- ATK_RECOVER: exit to IDLE at a tick with pcnt==ATK_RECOVER-1.
- Each attack state therefore lasts exactly its parameter in frames. The attack cannot be cancelled by shield or movement.
- SHIELD: at tick, shield released -> SHIELD_COOL. Else if pcnt==SHIELD_MAX-1 -> SHIELD_COOL (forced drop). Attack edges are discarded.
- SHIELD_COOL: exit to IDLE at a tick with pcnt==SHIELD_CD-1. No shield or attack entry during cooldown.
- IDLE after recovery/cooldown: re-evaluated at the next tick. A held shield then re-enters SHIELD; an attack held down does not re-trigger (edge required).
- All outputs are registered, decoded from the registered state.
- Reset mid-operation: reset_n=0 on any cycle, including a tick cycle, overrides everything.

Test Plan:
- Reset/tick: TICK_DIV=4; hold reset_n=0 for 3 cycles, then release -> all outputs 0; frame_tick pulses on cycles 3, 7, 11 after release; state=0.
- Attack sequence: params 2/3/2, TICK_DIV=4; pulse attack 2 cycles -> state 2 for 2 ticks, 3 for 3 ticks (hitbox_active=1 exactly 12 cycles), 4 for 2 ticks, then 0; busy=1 for 28 cycles.
- Priority and discard: press attack and shield together before a tick -> ATK_START. Keep shield held and tap attack during ATK_ACTIVE -> no second attack. After recovery, state goes to SHIELD at the next tick.
- Shield timeout: SHIELD_MAX=5, SHIELD_CD=3, hold shield -> shielding=1 for 5 ticks, SHIELD_COOL for 3 ticks, then re-enter SHIELD at the following tick.
- Movement: left_l=0 with right_l=1 -> MOVE with move_left=1. Then drive left_l=0 and right_l=0 -> next tick goes to IDLE with all move outputs 0. up_l=0 alone -> jump=1.
- Reset mid-attack: assert reset_n=0 for 1 cycle during ATK_ACTIVE -> next cycle hitbox_active=0, state=0; a prior attack edge is not replayed.
